// File: rtl/vend_fsm_param.sv
// Parametrised vending-machine controller: saturating credit, index-priced products,
// timed dispense pulse and change/refund payout. All outputs are registered.
module vend_fsm_param #(
    parameter  int CREDIT_W    = 5,
    parameter  int COIN_W      = 3,
    parameter  int NUM_PROD    = 4,
    parameter  int PRICE_BASE  = 3,
    parameter  int PRICE_STEP  = 2,
    parameter  int DISP_CYCLES = 2,
    localparam int SEL_W       = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_coin_valid,
    input  logic [COIN_W-1:0]   i_coin_val,
    input  logic                i_buy,
    input  logic [SEL_W-1:0]    i_sel,
    input  logic                i_cancel,
    output logic [CREDIT_W-1:0] o_credit,
    output logic                o_coin_reject,
    output logic                o_buy_deny,
    output logic                o_dispense,
    output logic [SEL_W-1:0]    o_disp_id,
    output logic                o_change_valid,
    output logic [CREDIT_W-1:0] o_change_amt,
    output logic                o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_t;

    localparam int                CW1   = CREDIT_W + 1;
    localparam int                CNT_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
    localparam logic [CREDIT_W:0] MAXC  = CW1'((1 << CREDIT_W) - 1);

    function automatic logic [CREDIT_W:0] price_f(input logic [SEL_W-1:0] idx);
        price_f = CW1'(PRICE_BASE + int'(idx) * PRICE_STEP);
    endfunction

    state_t                r_state;
    logic [CREDIT_W-1:0]   r_credit;
    logic                  r_coin_reject;
    logic                  r_buy_deny;
    logic                  r_dispense;
    logic [SEL_W-1:0]      r_disp_id;
    logic                  r_change_valid;
    logic [CREDIT_W-1:0]   r_change_amt;
    logic                  r_busy;
    logic [CNT_W-1:0]      r_cnt;

    state_t                w_state_nx;
    logic [CREDIT_W-1:0]   w_credit_nx;
    logic                  w_coin_reject_nx;
    logic                  w_buy_deny_nx;
    logic                  w_dispense_nx;
    logic [SEL_W-1:0]      w_disp_id_nx;
    logic                  w_change_valid_nx;
    logic [CREDIT_W-1:0]   w_change_amt_nx;
    logic [CNT_W-1:0]      w_cnt_nx;
    logic [CREDIT_W:0]     w_sum;
    logic [CREDIT_W:0]     w_price;
    logic                  w_coin_ok;
    logic                  w_buy_ok;
    logic                  w_cancel_act;

    // Next-state, next-credit and next-output decode.
    always_comb begin
        w_state_nx        = r_state;
        w_credit_nx       = r_credit;
        w_coin_reject_nx  = 1'b0;
        w_buy_deny_nx     = 1'b0;
        w_dispense_nx     = 1'b0;
        w_disp_id_nx      = r_disp_id;
        w_change_valid_nx = 1'b0;
        w_change_amt_nx   = '0;
        w_cnt_nx          = r_cnt;

        // Sum kept one bit wider so an overflowing coin is detected instead of wrapping.
        w_sum        = {1'b0, r_credit} + CW1'(i_coin_val);
        w_coin_ok    = (i_coin_val != '0) && (w_sum <= MAXC);
        w_price      = price_f(i_sel);
        w_buy_ok     = (int'(i_sel) < NUM_PROD) && ({1'b0, r_credit} >= w_price);
        w_cancel_act = i_cancel && (r_state == ST_HOLD);

        case (r_state)
            ST_IDLE, ST_HOLD: begin
                if (w_cancel_act) begin
                    w_state_nx        = ST_CHANGE;
                    w_change_valid_nx = 1'b1;
                    w_change_amt_nx   = r_credit;
                    w_coin_reject_nx  = i_coin_valid;
                    w_buy_deny_nx     = i_buy;
                end else if (i_buy) begin
                    w_coin_reject_nx = i_coin_valid;
                    if (w_buy_ok) begin
                        w_state_nx    = ST_VEND;
                        w_dispense_nx = 1'b1;
                        w_disp_id_nx  = i_sel;
                        w_credit_nx   = r_credit - w_price[CREDIT_W-1:0];
                        w_cnt_nx      = CNT_W'(DISP_CYCLES - 1);
                    end else begin
                        w_buy_deny_nx = 1'b1;
                    end
                end else if (i_coin_valid) begin
                    if (w_coin_ok) begin
                        w_credit_nx = w_sum[CREDIT_W-1:0];
                        w_state_nx  = ST_HOLD;
                    end else begin
                        w_coin_reject_nx = 1'b1;
                    end
                end else begin
                    w_state_nx = r_state;
                end
            end
            ST_VEND: begin
                w_coin_reject_nx = i_coin_valid;
                w_buy_deny_nx    = i_buy;
                if (r_cnt == '0) begin
                    if (r_credit != '0) begin
                        w_state_nx        = ST_CHANGE;
                        w_change_valid_nx = 1'b1;
                        w_change_amt_nx   = r_credit;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end else begin
                    w_cnt_nx      = r_cnt - CNT_W'(1);
                    w_dispense_nx = 1'b1;
                end
            end
            ST_CHANGE: begin
                w_coin_reject_nx = i_coin_valid;
                w_buy_deny_nx    = i_buy;
                w_credit_nx      = '0;
                w_state_nx       = ST_IDLE;
            end
            default: begin
                w_state_nx  = ST_IDLE;
                w_credit_nx = '0;
            end
        endcase
    end

    // State and registered-output update; reset aborts any sale in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_credit       <= '0;
            r_coin_reject  <= 1'b0;
            r_buy_deny     <= 1'b0;
            r_dispense     <= 1'b0;
            r_disp_id      <= '0;
            r_change_valid <= 1'b0;
            r_change_amt   <= '0;
            r_busy         <= 1'b0;
            r_cnt          <= '0;
        end else begin
            r_state        <= w_state_nx;
            r_credit       <= w_credit_nx;
            r_coin_reject  <= w_coin_reject_nx;
            r_buy_deny     <= w_buy_deny_nx;
            r_dispense     <= w_dispense_nx;
            r_disp_id      <= w_disp_id_nx;
            r_change_valid <= w_change_valid_nx;
            r_change_amt   <= w_change_amt_nx;
            r_busy         <= (w_state_nx == ST_VEND) || (w_state_nx == ST_CHANGE);
            r_cnt          <= w_cnt_nx;
        end
    end

    assign o_credit       = r_credit;
    assign o_coin_reject  = r_coin_reject;
    assign o_buy_deny     = r_buy_deny;
    assign o_dispense     = r_dispense;
    assign o_disp_id      = r_disp_id;
    assign o_change_valid = r_change_valid;
    assign o_change_amt   = r_change_amt;
    assign o_busy         = r_busy;

endmodule
